// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR core: FSM state encoding and default taps.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKUP = 2'd2
  } lfsr_state_e;

  localparam int unsigned MAX_NBITS = 64;

  // Default feedback mask, wide enough to be sliced down to any legal NBITS.
  localparam logic [MAX_NBITS-1:0] DEFAULT_TAPS = 64'h0000_0000_0000_002D;

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// One combinational LFSR step: shift toward bit 0, feedback parity of (state & taps) into the MSB.
module lfsr_step #(
  parameter int NBITS = 16
) (
  input  logic [NBITS-1:0] state_i,
  input  logic [NBITS-1:0] taps_i,
  output logic [NBITS-1:0] next_o
);

  logic fb;

  assign fb     = ^(state_i & taps_i);
  assign next_o = {fb, state_i[NBITS-1:1]};

endmodule : lfsr_step

// File: rtl/lfsr_core.sv
// Programmable Fibonacci LFSR with valid/ready output, lockup detection and period measurement.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               NBITS      = 16,
  parameter int               NSTEPS     = 1,
  parameter logic [NBITS-1:0] RESET_SEED = NBITS'(1),
  parameter logic [NBITS-1:0] RESET_TAPS = DEFAULT_TAPS[NBITS-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] seed,
  input  logic [NBITS-1:0] taps,
  input  logic             start,
  input  logic             stop,
  input  logic             out_rdy,
  output logic             out_val,
  output logic [NBITS-1:0] q,
  output logic             lockup,
  output logic             wrapped,
  output logic [NBITS-1:0] period
);

  lfsr_state_e      state_q, state_d;
  logic [NBITS-1:0] q_q, q_d;
  logic [NBITS-1:0] taps_q, taps_d;
  logic [NBITS-1:0] seed_q, seed_d;
  logic [NBITS-1:0] count_q, count_d;
  logic [NBITS-1:0] period_q, period_d;
  logic             wrapped_q, wrapped_d;
  logic             lockup_q, lockup_d;

  logic             xfer;
  logic [NBITS-1:0] adv;
  logic [NBITS-1:0] chain [NSTEPS+1];

  // NSTEPS single steps chained so one transfer advances the state NSTEPS times.
  assign chain[0] = q_q;
  for (genvar g = 0; g < NSTEPS; g++) begin : g_step
    lfsr_step #(.NBITS(NBITS)) u_step (
      .state_i (chain[g]),
      .taps_i  (taps_q),
      .next_o  (chain[g+1])
    );
  end
  assign adv = chain[NSTEPS];

  assign out_val = (state_q == RUN);
  assign xfer    = out_val & out_rdy;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    q_d       = q_q;
    taps_d    = taps_q;
    seed_d    = seed_q;
    count_d   = count_q;
    period_d  = period_q;
    wrapped_d = 1'b0;

    if (load) begin
      q_d     = seed;
      taps_d  = taps;
      seed_d  = seed;
      count_d = '0;
      state_d = IDLE;
    end else begin
      if (xfer) begin
        q_d = adv;
        // Only the post-advance state is compared with the seed, even for multi-step transfers.
        if (adv == seed_q) begin
          wrapped_d = 1'b1;
          period_d  = count_q + NBITS'(1);
          count_d   = '0;
        end else begin
          count_d = count_q + NBITS'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (start) state_d = (q_q == '0) ? LOCKUP : RUN;
        end
        RUN: begin
          if (stop)                     state_d = IDLE;
          else if (xfer && adv == '0)   state_d = LOCKUP;
        end
        LOCKUP:  state_d = LOCKUP;
        default: state_d = IDLE;
      endcase
    end

    lockup_d = (state_d == LOCKUP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      q_q       <= RESET_SEED;
      taps_q    <= RESET_TAPS;
      seed_q    <= RESET_SEED;
      count_q   <= '0;
      period_q  <= '0;
      wrapped_q <= 1'b0;
      lockup_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      q_q       <= q_d;
      taps_q    <= taps_d;
      seed_q    <= seed_d;
      count_q   <= count_d;
      period_q  <= period_d;
      wrapped_q <= wrapped_d;
      lockup_q  <= lockup_d;
    end
  end

  assign q       = q_q;
  assign lockup  = lockup_q;
  assign wrapped = wrapped_q;
  assign period  = period_q;

endmodule : lfsr_core

// File: doc/lfsr_core.md
LFSR_CORE -- requirements
Module: lfsr_core

Interface
REQ-001 Parameter NBITS, default 16: register width, 2..64.
REQ-002 Parameter NSTEPS, default 1: LFSR steps per accepted transfer, 1..NBITS.
REQ-003 Parameter RESET_SEED, default 1: state value after reset.
REQ-004 Parameter RESET_TAPS, default 16'h002D: tap mask after reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-007 load  in  1  capture seed and taps; force IDLE.
REQ-008 seed  in  NBITS  state loaded on load.
REQ-009 taps  in  NBITS  feedback mask loaded on load.
REQ-010 start  in  1  IDLE->RUN request.
REQ-011 stop  in  1  RUN->IDLE request.
REQ-012 out_rdy  in  1  consumer accepts q.
REQ-013 out_val  out  1  q valid for transfer.
REQ-014 q  out  NBITS  current LFSR state.
REQ-015 lockup  out  1  high while in LOCKUP.
REQ-016 wrapped  out  1  one-cycle pulse on return to captured seed.
REQ-017 period  out  NBITS  transfer count of last completed cycle.

Function
REQ-018 One step: fb = XOR-reduce(q & taps_r); q[i] <= q[i+1] for i < NBITS-1; q[NBITS-1] <= fb.
REQ-019 Transfer (out_val & out_rdy) advances q by NSTEPS chained steps in one cycle; no other event changes q except load.
REQ-020 FSM states IDLE, RUN, LOCKUP; out_val = 1 only in RUN.
REQ-021 Priority per cycle: load > stop > start > transfer-side transitions.
REQ-022 load, any state: q <= seed, taps_r <= taps, seed_r <= seed, count <= 0, state <= IDLE, wrapped <= 0; period holds.
REQ-023 IDLE & start: q == 0 -> LOCKUP; otherwise -> RUN.
REQ-024 RUN & stop: a transfer in the same cycle completes; next state IDLE.
REQ-025 RUN transfer with next-state == 0 -> LOCKUP; q takes the zero value.
REQ-026 LOCKUP exits only via load or reset; start and stop are ignored.
REQ-027 count (NBITS, internal) increments by 1 per transfer, wrapping mod 2^NBITS.
REQ-028 Transfer with next-state == seed_r: wrapped = 1 next cycle, period <= count+1, count <= 0.
REQ-029 For NSTEPS > 1, wrap is checked only on the post-advance state; intermediate states are not compared.
REQ-030 lockup is registered; it equals (state == LOCKUP).
REQ-031 No backpressure storage: q is stable while out_val & !out_rdy.

Reset
REQ-032 Reset asserted: q = RESET_SEED, taps_r = RESET_TAPS, seed_r = RESET_SEED, state = IDLE, count = 0, period = 0, wrapped = 0, lockup = 0, out_val = 0.
REQ-033 Reset mid-RUN aborts immediately with no partial advance; deassertion is synchronised externally.

Structure
REQ-034 Package lfsr_pkg holds the state enum typedef (IDLE, RUN, LOCKUP) and the default tap constant.
REQ-035 Combinational sub-module lfsr_step (one step, parameter NBITS) is instantiated NSTEPS times in a chain.

Verification
REQ-036 NBITS=4, NSTEPS=1, load seed=0001 taps=0011, start, out_rdy=1 -> q sequence 1000,0100,0010,1001,…,0011,0001; wrapped pulses after transfer 15; period=15.
REQ-037 Same setup, out_rdy toggled 1/0 -> q advances only on ready cycles; period still 15.
REQ-038 load seed=0000, start -> LOCKUP, lockup=1, out_val=0; start is ignored; load seed=0001 -> IDLE, lockup=0.
REQ-039 NBITS=4, NSTEPS=2, seed=0001, taps=0011 -> q 0100,1001,0110,0101,1101,1111,0011,1000,… ; wrapped on return to 0001 after 15 transfers (odd period, crosses seed on second lap), period=15.
REQ-040 RUN with stop and load asserted in the same cycle -> load wins; q=seed, IDLE, count=0.
REQ-041 reset asserted mid-RUN (async, between edges) -> outputs take REQ-032 values immediately; q=RESET_SEED.
